// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register for the 16-bit 5-stage pipeline.
// Holds the PC, requests words from instruction memory and hands them to decode.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    output logic        imem_en,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] instr,
    output logic [15:0] pc_plus2,
    output logic        if_valid,
    output logic        halted,
    output logic        err,
    output logic [15:0] fetch_count
);

    // Handshake: a word is taken only on an edge where imem_en=1, imem_ready=1,
    // stall=0 and redirect_en=0; otherwise imem_addr is held until accepted.
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_pc_plus2;
    logic        r_if_valid;
    logic        r_err;
    logic [15:0] r_fetch_count;

    logic [15:0] w_pc_next;
    logic        w_is_halt;

    assign w_pc_next = r_pc + 16'd2;
    assign w_is_halt = (imem_rdata[15:11] == HALT_OPC);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_pc_plus2    <= 16'h0000;
            r_if_valid    <= 1'b0;
            r_err         <= 1'b0;
            r_fetch_count <= 16'h0000;
        end else if (redirect_en) begin
            // Redirect wins over stall and ready in both states; also squashes a HALT.
            r_state    <= RUN;
            r_pc       <= {redirect_pc[15:1], 1'b0};
            r_instr    <= NOP_INSTR;
            r_if_valid <= 1'b0;
            if (redirect_pc[0]) begin
                r_err <= 1'b1;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (stall) begin
                        r_pc <= r_pc;
                    end else if (imem_ready) begin
                        r_instr       <= imem_rdata;
                        r_pc_plus2    <= w_pc_next;
                        r_if_valid    <= 1'b1;
                        r_fetch_count <= r_fetch_count + 16'd1;
                        if (w_is_halt) begin
                            r_state <= HALTED;
                        end else begin
                            r_pc <= w_pc_next;
                        end
                    end else begin
                        r_instr    <= NOP_INSTR;
                        r_if_valid <= 1'b0;
                    end
                end
                HALTED: begin
                    if (!stall) begin
                        r_instr    <= NOP_INSTR;
                        r_if_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign imem_en     = (r_state == RUN);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign pc_plus2    = r_pc_plus2;
    assign if_valid    = r_if_valid;
    assign halted      = (r_state == HALTED);
    assign err         = r_err;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID contents are queued at issue time
// and a monitor checks them on the cycle after each accepted memory handshake.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] instr;
  logic [15:0] pc_plus2;
  logic        if_valid;
  logic        halted;
  logic        err;
  logic [15:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  // {instr, pc_plus2, fetch_count}
  logic [47:0] exp_q[$];
  logic        pend = 1'b0;

  fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .instr(instr),
    .pc_plus2(pc_plus2),
    .if_valid(if_valid),
    .halted(halted),
    .err(err),
    .fetch_count(fetch_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] i, input logic [15:0] p2, input logic [15:0] cnt);
    exp_q.push_back({i, p2, cnt});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, imem_addr, 16'h0000);
    chk({tag, "_instr"}, instr, 16'h0800);
    chk({tag, "_pc_plus2"}, pc_plus2, 16'h0000);
    chk({tag, "_if_valid"}, {15'd0, if_valid}, 16'd0);
    chk({tag, "_halted"}, {15'd0, halted}, 16'd0);
    chk({tag, "_err"}, {15'd0, err}, 16'd0);
    chk({tag, "_fetch_count"}, fetch_count, 16'h0000);
    chk({tag, "_imem_en"}, {15'd0, imem_en}, 16'd1);
  endtask

  // scoreboard monitor: one edge after an accepted handshake, IF/ID must hold the word
  always @(negedge clk) begin
    logic [47:0] e;
    if (pend) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got instr %h with no expected entry", instr);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", instr, e[47:32]);
        chk("sb_pc_plus2", pc_plus2, e[31:16]);
        chk("sb_fetch_count", fetch_count, e[15:0]);
        chk("sb_if_valid", {15'd0, if_valid}, 16'd1);
      end
    end
    pend = rst && imem_en && imem_ready && !stall && !redirect_en;
  end

  initial begin
    rst = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 16'h0000;
    imem_rdata = 16'h0000; imem_ready = 1'b0;
    step(); step();
    chk_reset_vals("reset");

    // zero-wait fetch of two words
    rst = 1'b1; imem_ready = 1'b1; imem_rdata = 16'h4000;
    push(16'h4000, 16'h0002, 16'd1);
    step();
    chk("seq_addr1", imem_addr, 16'h0002);
    imem_rdata = 16'h4100;
    push(16'h4100, 16'h0004, 16'd2);
    step();
    chk("seq_addr2", imem_addr, 16'h0004);
    chk("seq_count", fetch_count, 16'd2);

    // three wait cycles then accept
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_addr", imem_addr, 16'h0004);
      chk("wait_instr", instr, 16'h0800);
      chk("wait_valid", {15'd0, if_valid}, 16'd0);
    end
    imem_ready = 1'b1; imem_rdata = 16'h5555;
    push(16'h5555, 16'h0006, 16'd3);
    step();

    // stall holds everything even with ready high
    stall = 1'b1; imem_rdata = 16'h7777;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_instr", instr, 16'h5555);
      chk("stall_pc_plus2", pc_plus2, 16'h0006);
      chk("stall_valid", {15'd0, if_valid}, 16'd1);
      chk("stall_addr", imem_addr, 16'h0006);
      chk("stall_count", fetch_count, 16'd3);
    end

    // redirect beats stall
    redirect_en = 1'b1; redirect_pc = 16'h0040;
    step();
    chk("redir_addr", imem_addr, 16'h0040);
    chk("redir_valid", {15'd0, if_valid}, 16'd0);
    chk("redir_instr", instr, 16'h0800);
    chk("redir_err", {15'd0, err}, 16'd0);

    // odd redirect target sets sticky err
    stall = 1'b0; redirect_pc = 16'h0041;
    step();
    chk("odd_addr", imem_addr, 16'h0040);
    chk("odd_err", {15'd0, err}, 16'd1);
    redirect_en = 1'b0; imem_rdata = 16'h4200;
    push(16'h4200, 16'h0042, 16'd4);
    step();
    imem_rdata = 16'h4300;
    push(16'h4300, 16'h0044, 16'd5);
    step();
    chk("sticky_err", {15'd0, err}, 16'd1);
    chk("sticky_addr", imem_addr, 16'h0044);

    // HALT fetched at 0010
    redirect_en = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect_en = 1'b0; imem_rdata = 16'h0000;
    push(16'h0000, 16'h0012, 16'd6);
    step();
    chk("halt_halted", {15'd0, halted}, 16'd1);
    chk("halt_en", {15'd0, imem_en}, 16'd0);
    chk("halt_addr", imem_addr, 16'h0010);
    chk("halt_instr", instr, 16'h0000);
    imem_rdata = 16'h1234;
    step();
    chk("halt_bubble_instr", instr, 16'h0800);
    chk("halt_bubble_valid", {15'd0, if_valid}, 16'd0);
    chk("halt_hold_addr", imem_addr, 16'h0010);
    chk("halt_still", {15'd0, halted}, 16'd1);
    redirect_en = 1'b1; redirect_pc = 16'h0020;
    step();
    chk("unhalt_halted", {15'd0, halted}, 16'd0);
    chk("unhalt_addr", imem_addr, 16'h0020);
    chk("unhalt_en", {15'd0, imem_en}, 16'd1);
    redirect_en = 1'b0; imem_rdata = 16'h4400;
    push(16'h4400, 16'h0022, 16'd7);
    step();

    // reset while HALTED with a redirect pending
    imem_rdata = 16'h0000;
    push(16'h0000, 16'h0024, 16'd8);
    step();
    chk("halt2_halted", {15'd0, halted}, 16'd1);
    rst = 1'b0; redirect_en = 1'b1; redirect_pc = 16'h0030;
    step();
    chk_reset_vals("rst_halted");

    // reset in the middle of a memory wait
    rst = 1'b1; redirect_en = 1'b0; imem_rdata = 16'h4500;
    push(16'h4500, 16'h0002, 16'd1);
    step();
    imem_ready = 1'b0;
    step();
    chk("midwait_addr", imem_addr, 16'h0002);
    rst = 1'b0;
    step();
    chk_reset_vals("rst_wait");

    // PC wraps from FFFE to 0000 without error
    rst = 1'b1; redirect_en = 1'b1; redirect_pc = 16'hFFFE;
    step();
    chk("wrap_pre_addr", imem_addr, 16'hFFFE);
    redirect_en = 1'b0; imem_ready = 1'b1; imem_rdata = 16'h4600;
    push(16'h4600, 16'h0000, 16'd1);
    step();
    chk("wrap_addr", imem_addr, 16'h0000);
    chk("wrap_err", {15'd0, err}, 16'd0);

    imem_ready = 1'b0;
    step(); step();
    chk("sb_drained", exp_q.size()[15:0], 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
